// File: rtl/c16_muldiv.sv
// c16_muldiv: iterative multiply/divide unit for the c16 core family.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit per
// cycle, on magnitudes. Signs are applied in a final FIX cycle.
// op: 00 mulu, 01 muls, 10 divu, 11 divs.
// Optional feature macro: MULDIV_ABORT_EN adds an abort input that cancels a
// running operation without producing done.
module c16_muldiv #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
`ifdef MULDIV_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);

   localparam int AW = 2 * WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               is_div_q, is_div_d;
   logic               neg_lo_q, neg_lo_d;   // negate product / quotient
   logic               neg_hi_q, neg_hi_d;   // negate remainder
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;     // dividend as given, for divide-by-zero
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;

   logic               accept;
   logic               abort_act;
   logic               b_is_zero;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   logic [WIDTH:0]     mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [AW-1:0]      mul_next;
   logic [AW-1:0]      div_sh;
   logic               div_ge;
   logic [WIDTH:0]     div_trial;
   logic [AW-1:0]      div_next;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

`ifdef MULDIV_ABORT_EN
   logic               dbz_save_q, dbz_save_d;  // div_by_zero before the accept, restored on abort
   assign abort_act = abort && busy;
`else
   assign abort_act = 1'b0;
`endif

   assign accept    = (state_q == S_IDLE) && start;
   assign b_is_zero = (b == {WIDTH{1'b0}});

   // Operand magnitudes; signs only matter for the signed ops (op[0]).
   assign a_neg = op[0] && a[WIDTH-1];
   assign b_neg = op[0] && b[WIDTH-1];
   assign a_mag = a_neg ? ({WIDTH{1'b0}} - a) : a;
   assign b_mag = b_neg ? ({WIDTH{1'b0}} - b) : b;

   // One shift-add step: add multiplicand into the upper half when the
   // current multiplier bit (acc[0]) is set, then shift right.
   always_comb begin
      mul_add  = acc_q[0] ? {1'b0, b_mag_q} : {(WIDTH+1){1'b0}};
      mul_sum  = acc_q[AW-1:WIDTH] + mul_add;
      mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
   end

   // One restoring divide step: shift left, try subtracting the divisor from
   // the partial remainder, keep the difference and set the quotient bit if
   // it did not go negative.
   always_comb begin
      div_sh    = {acc_q[AW-2:0], 1'b0};
      div_ge    = (div_sh[AW-1:WIDTH] >= {1'b0, b_mag_q});
      div_trial = div_sh[AW-1:WIDTH] - {1'b0, b_mag_q};
      div_next  = div_ge ? {div_trial, div_sh[WIDTH-1:1], 1'b1} : div_sh;
   end

   // Sign correction of the finished magnitude results.
   always_comb begin
      prod_fix = neg_lo_q ? ({(2*WIDTH){1'b0}} - acc_q[2*WIDTH-1:0]) : acc_q[2*WIDTH-1:0];
      quot_fix = neg_lo_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_fix  = neg_hi_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
   end

   // FSM next-state: IDLE -> RUN (or FIX on divide-by-zero) -> FIX -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (op[1] && b_is_zero) ? S_FIX : S_RUN;
            end
         end
         S_RUN: begin
            if (abort_act) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = abort_act ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath next values: capture on accept, iterate in RUN, load results in FIX.
   always_comb begin
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      dbz_d    = dbz_q;
      a_raw_d  = a_raw_q;
      b_mag_d  = b_mag_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
`ifdef MULDIV_ABORT_EN
      dbz_save_d = dbz_save_q;
`endif
      if (accept) begin
         is_div_d = op[1];
         neg_lo_d = a_neg ^ b_neg;
         neg_hi_d = a_neg;
         dbz_d    = op[1] && b_is_zero;
         a_raw_d  = a;
         b_mag_d  = b_mag;
         cnt_d    = CNT_W'(WIDTH);
         acc_d    = {{(WIDTH+1){1'b0}}, a_mag};
`ifdef MULDIV_ABORT_EN
         dbz_save_d = dbz_q;
`endif
      end else if (abort_act) begin
`ifdef MULDIV_ABORT_EN
         dbz_d = dbz_save_q;
`endif
      end else if (state_q == S_RUN) begin
         cnt_d = cnt_q - CNT_W'(1);
         acc_d = is_div_q ? div_next : mul_next;
      end else if (state_q == S_FIX) begin
         if (!is_div_q) begin
            res_lo_d = prod_fix[WIDTH-1:0];
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
         end else if (dbz_q) begin
            res_lo_d = {WIDTH{1'b1}};
            res_hi_d = a_raw_q;
         end else begin
            res_lo_d = quot_fix;
            res_hi_d = rem_fix;
         end
      end
   end

   // State and datapath registers; asynchronous reset clears everything.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         dbz_q      <= 1'b0;
         a_raw_q    <= '0;
         b_mag_q    <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         res_lo_q   <= '0;
         res_hi_q   <= '0;
`ifdef MULDIV_ABORT_EN
         dbz_save_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         dbz_q      <= dbz_d;
         a_raw_q    <= a_raw_d;
         b_mag_q    <= b_mag_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         res_lo_q   <= res_lo_d;
         res_hi_q   <= res_hi_d;
`ifdef MULDIV_ABORT_EN
         dbz_save_q <= dbz_save_d;
`endif
      end
   end

   assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign result_lo   = res_lo_q;
   assign result_hi   = res_hi_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_c16_muldiv.sv
// Self-checking bench for c16_muldiv (WIDTH=16): directed cases plus random
// operations compared against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_c16_muldiv;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
`ifdef MULDIV_ABORT_EN
   logic         abort = 1'b0;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] result_lo;
   logic [W-1:0] result_hi;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] last_lo = '0;
   logic [W-1:0] last_hi = '0;
   logic         last_dz = 1'b0;

   always #5 clk = ~clk;

   c16_muldiv #(.WIDTH(W), .CNT_W(5)) dut (
      .clk         (clk),
      .resetn      (resetn),
`ifdef MULDIV_ABORT_EN
      .abort       (abort),
`endif
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result_lo   (result_lo),
      .result_hi   (result_hi),
      .div_by_zero (div_by_zero)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on sign-interpreted operands.
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
      longint sx, sy, p, q, r;
      sx = (o[0] && x[W-1]) ? longint'(x) - 65536 : longint'(x);
      sy = (o[0] && y[W-1]) ? longint'(y) - 65536 : longint'(y);
      dz = 1'b0;
      if (!o[1]) begin
         p  = sx * sy;
         lo = p[15:0];
         hi = p[31:16];
      end else if (y == '0) begin
         lo = '1;
         hi = x;
         dz = 1'b1;
      end else begin
         q  = sx / sy;
         r  = sx % sy;
         lo = q[15:0];
         hi = r[15:0];
      end
   endtask

   // Issue one operation and check latency, busy window, results and hold.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit disturb, input string tag);
      logic [W-1:0] elo, ehi;
      logic         edz;
      int           lat, busy_cnt, exp_lat, extra_done;
      logic         busy_at_done;
      model(o, x, y, elo, ehi, edz);
      exp_lat = (o[1] && y == '0) ? 2 : W + 2;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; busy_cnt = 0; busy_at_done = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            busy_at_done = busy;
            break;
         end
         if (busy) busy_cnt++;
         if (disturb && k == 5) begin start = 1'b1; op = 2'b00; a = 16'd9; b = 16'd9; end
         if (disturb && k == 6) begin start = 1'b0; a = 16'h0055; end
      end
      $display("op=%0d a=0x%04h b=0x%04h -> lo=0x%04h hi=0x%04h dz=%0d lat=%0d [%s]",
               o, x, y, result_lo, result_hi, div_by_zero, lat, tag);
      check_eq({tag, " latency"}, lat, exp_lat);
      check_eq({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
      check_eq({tag, " busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
      check_eq({tag, " lo"}, {16'd0, result_lo}, {16'd0, elo});
      check_eq({tag, " hi"}, {16'd0, result_hi}, {16'd0, ehi});
      check_eq({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
      @(negedge clk);
      check_eq({tag, " done_single"}, {31'd0, done}, 32'd0);
      check_eq({tag, " lo_hold"}, {16'd0, result_lo}, {16'd0, elo});
      if (disturb) begin
         extra_done = 0;
         for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) extra_done++;
         end
         check_eq({tag, " no_second_done"}, extra_done, 0);
      end
      last_lo = elo; last_hi = ehi; last_dz = edz;
   endtask

   initial begin
      int dcount;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      // Reset state
      #12;
      check_eq("rst busy", {31'd0, busy}, 32'd0);
      check_eq("rst done", {31'd0, done}, 32'd0);
      check_eq("rst lo", {16'd0, result_lo}, 32'd0);
      check_eq("rst hi", {16'd0, result_hi}, 32'd0);
      check_eq("rst dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, "mulu_max");
      run_op(2'b01, 16'hFFFD, 16'h0005, 1'b0, "muls_neg");
      run_op(2'b11, 16'hFFF9, 16'h0002, 1'b0, "divs_neg");
      run_op(2'b10, 16'h0064, 16'h0000, 1'b0, "divu_zero");
      run_op(2'b10, 16'h0064, 16'h0007, 1'b0, "divu_100_7");
      run_op(2'b11, 16'h8000, 16'hFFFF, 1'b0, "divs_min");
      run_op(2'b11, 16'h8001, 16'h0000, 1'b0, "divs_zero");
      run_op(2'b00, 16'h0003, 16'h0004, 1'b1, "ignored_start");

      // Reset asserted in the middle of a divide
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 16'd1000; b = 16'd3;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k < 8; k++) @(negedge clk);
      resetn = 1'b0;
      #1;
      $display("reset mid-op: busy=%0d done=%0d lo=0x%04h hi=0x%04h dz=%0d",
               busy, done, result_lo, result_hi, div_by_zero);
      check_eq("midrst busy", {31'd0, busy}, 32'd0);
      check_eq("midrst lo", {16'd0, result_lo}, 32'd0);
      check_eq("midrst hi", {16'd0, result_hi}, 32'd0);
      check_eq("midrst dbz", {31'd0, div_by_zero}, 32'd0);
      dcount = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      resetn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check_eq("midrst no_done", dcount, 0);
      run_op(2'b10, 16'd1000, 16'd3, 1'b0, "after_reset");

`ifdef MULDIV_ABORT_EN
      run_op(2'b10, 16'h0042, 16'h0000, 1'b0, "pre_abort_dbz");
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h0010;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 4; k++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      $display("abort: busy=%0d lo=0x%04h hi=0x%04h dz=%0d", busy, result_lo, result_hi, div_by_zero);
      check_eq("abort busy", {31'd0, busy}, 32'd0);
      check_eq("abort lo", {16'd0, result_lo}, {16'd0, last_lo});
      check_eq("abort hi", {16'd0, result_hi}, {16'd0, last_hi});
      check_eq("abort dbz", {31'd0, div_by_zero}, {31'd0, last_dz});
      dcount = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check_eq("abort no_done", dcount, 0);
`endif

      // Random operations with occasional boundary operands
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 16'h8000; rb = 16'hFFFF; end
            2: rb = 16'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(ro, ra, rb, 1'b0, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
